// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bus of the branch resolve unit: prediction enqueue,
// resolution, predictor update, redirect and status.
interface branch_resolve_unit_if #(
  parameter int PC_W  = 64,
  parameter int IDX_W = 5
) ();
  logic             pred_valid;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_en;
  logic [IDX_W-1:0] upd_addr;
  logic             upd_taken;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [31:0]      mispred_cnt;
  logic             underflow_err;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_en, upd_addr, upd_taken,
    input  redirect, redirect_pc, mispred_cnt, underflow_err
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_en, upd_addr, upd_taken,
    output redirect, redirect_pc, mispred_cnt, underflow_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-flight branch queue: checks resolutions against the oldest prediction,
// trains the predictor, and flushes/redirects fetch on a mispredict.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64,
  parameter int IDX_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_mem_r     [DEPTH];
  logic             taken_mem_r  [DEPTH];
  logic [PC_W-1:0]  target_mem_r [DEPTH];

  logic [PTR_W-1:0] head_r, tail_r;
  logic [CNT_W-1:0] count_r;
  logic             upd_en_r, upd_taken_r, redirect_r, underflow_r;
  logic [IDX_W-1:0] upd_addr_r;
  logic [PC_W-1:0]  redirect_pc_r;
  logic [31:0]      mispred_cnt_r;

  logic             ready_s, do_res_s, mispred_s, do_enq_s, do_pop_s;
  logic [PC_W-1:0]  head_pc_s, head_target_s, correct_pc_s;
  logic             head_taken_s;

  // Head lookup, mispredict detection and enqueue/pop qualification.
  always_comb begin
    ready_s       = (count_r < CNT_W'(DEPTH));
    head_pc_s     = pc_mem_r[head_r];
    head_taken_s  = taken_mem_r[head_r];
    head_target_s = target_mem_r[head_r];
    do_res_s      = bus.res_valid && (count_r != {CNT_W{1'b0}});
    mispred_s     = do_res_s &&
                    ((bus.res_taken != head_taken_s) ||
                     (bus.res_taken && head_taken_s && (bus.res_target != head_target_s)));
    correct_pc_s  = bus.res_taken ? bus.res_target : (head_pc_s + PC_W'(4));
    // A fetch issued alongside a mispredict is on the wrong path.
    do_enq_s      = bus.pred_valid && ready_s && !mispred_s;
    do_pop_s      = do_res_s && !mispred_s;
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (do_enq_s && !rst) begin
      pc_mem_r[tail_r]     <= bus.pred_pc;
      taken_mem_r[tail_r]  <= bus.pred_taken;
      target_mem_r[tail_r] <= bus.pred_target;
    end else begin
      pc_mem_r[tail_r]     <= pc_mem_r[tail_r];
      taken_mem_r[tail_r]  <= taken_mem_r[tail_r];
      target_mem_r[tail_r] <= target_mem_r[tail_r];
    end
  end

  // Queue pointers, update/redirect pulses and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      upd_en_r      <= 1'b0;
      upd_addr_r    <= {IDX_W{1'b0}};
      upd_taken_r   <= 1'b0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= {PC_W{1'b0}};
      mispred_cnt_r <= 32'd0;
      underflow_r   <= 1'b0;
    end else begin
      upd_en_r   <= do_res_s;
      redirect_r <= mispred_s;
      if (do_res_s) begin
        upd_addr_r  <= head_pc_s[IDX_W+1:2];
        upd_taken_r <= bus.res_taken;
      end
      if (mispred_s) begin
        redirect_pc_r <= correct_pc_s;
        head_r        <= tail_r;
        count_r       <= {CNT_W{1'b0}};
        if (mispred_cnt_r != 32'hFFFF_FFFF) begin
          mispred_cnt_r <= mispred_cnt_r + 32'd1;
        end
      end else begin
        if (do_enq_s) tail_r <= tail_r + PTR_W'(1);
        if (do_pop_s) head_r <= head_r + PTR_W'(1);
        count_r <= count_r + CNT_W'(do_enq_s) - CNT_W'(do_pop_s);
      end
      if (bus.res_valid && (count_r == {CNT_W{1'b0}})) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.pred_ready    = ready_s;
  assign bus.upd_en        = upd_en_r;
  assign bus.upd_addr      = upd_addr_r;
  assign bus.upd_taken     = upd_taken_r;
  assign bus.redirect      = redirect_r;
  assign bus.redirect_pc   = redirect_pc_r;
  assign bus.mispred_cnt   = mispred_cnt_r;
  assign bus.underflow_err = underflow_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit (DEPTH=4, PC_W=64, IDX_W=5);
// each vector is one clock, outputs checked 1ns after the rising edge.
module tb_branch_resolve_unit;
  typedef struct packed {
    logic        ready;
    logic        upd;
    logic [4:0]  addr;
    logic        ut;
    logic        redir;
    logic [63:0] rpc;
    logic [31:0] cnt;
    logic        uf;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        pv;
    logic [63:0] ppc;
    logic        pt;
    logic [63:0] ptg;
    logic        rv;
    logic        rt;
    logic [63:0] rtg;
    out_t        exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  vec_t vecs[$];

  branch_resolve_unit_if #(.PC_W(64), .IDX_W(5)) bus ();

  branch_resolve_unit #(.DEPTH(4), .PC_W(64), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic pv,
                              input logic [63:0] ppc, input logic pt, input logic [63:0] ptg,
                              input logic rv, input logic rt, input logic [63:0] rtg,
                              input logic ready, input logic upd, input logic [4:0] addr,
                              input logic ut, input logic redir, input logic [63:0] rpc,
                              input logic [31:0] cnt, input logic uf);
    vec_t v;
    v.name = name; v.rst = r; v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
    v.rv = rv; v.rt = rt; v.rtg = rtg;
    v.exp = '{ready: ready, upd: upd, addr: addr, ut: ut, redir: redir,
              rpc: rpc, cnt: cnt, uf: uf};
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    out_t got;
    rst             = v.rst;
    bus.pred_valid  = v.pv;
    bus.pred_pc     = v.ppc;
    bus.pred_taken  = v.pt;
    bus.pred_target = v.ptg;
    bus.res_valid   = v.rv;
    bus.res_taken   = v.rt;
    bus.res_target  = v.rtg;
    @(posedge clk);
    #1;
    got = '{ready: bus.pred_ready, upd: bus.upd_en, addr: bus.upd_addr, ut: bus.upd_taken,
            redir: bus.redirect, rpc: bus.redirect_pc, cnt: bus.mispred_cnt,
            uf: bus.underflow_err};
    n_checks++;
    if (got !== v.exp) begin
      $display("FAIL %s: got ready=%0b upd=%0b addr=%h ut=%0b redir=%0b rpc=%h cnt=%0d uf=%0b, expected ready=%0b upd=%0b addr=%h ut=%0b redir=%0b rpc=%h cnt=%0d uf=%0b",
               v.name, got.ready, got.upd, got.addr, got.ut, got.redir, got.rpc, got.cnt, got.uf,
               v.exp.ready, v.exp.upd, v.exp.addr, v.exp.ut, v.exp.redir, v.exp.rpc, v.exp.cnt, v.exp.uf);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.pred_valid = 1'b0; bus.pred_pc = 64'd0; bus.pred_taken = 1'b0; bus.pred_target = 64'd0;
    bus.res_valid  = 1'b0; bus.res_taken = 1'b0; bus.res_target = 64'd0;

    //                name            rst  pv   ppc                     pt   ptg        rv   rt   rtg       rdy  upd  addr   ut   rd   rpc        cnt    uf
    vecs.push_back(mk("reset",         1'b1,1'b0,64'h0,                  1'b0,64'h0,    1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,    32'd0,1'b0));
    // correct not-taken
    vecs.push_back(mk("enq_100",       1'b0,1'b1,64'h100,                1'b0,64'h104,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,    32'd0,1'b0));
    vecs.push_back(mk("res_nt_ok",     1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h00,1'b0,1'b0,64'h0,    32'd0,1'b0));
    vecs.push_back(mk("idle_0",        1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,    32'd0,1'b0));
    // direction mispredict, taken
    vecs.push_back(mk("enq_40",        1'b0,1'b1,64'h40,                 1'b0,64'h44,   1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,    32'd0,1'b0));
    vecs.push_back(mk("res_t_mis",     1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b1,64'h200, 1'b1,1'b1,5'h10,1'b1,1'b1,64'h200,  32'd1,1'b0));
    vecs.push_back(mk("idle_1",        1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b0,1'b0,64'h0,   1'b1,1'b0,5'h10,1'b1,1'b0,64'h200,  32'd1,1'b0));
    // target mispredict, then taken-predicted resolved not-taken
    vecs.push_back(mk("enq_80",        1'b0,1'b1,64'h80,                 1'b1,64'h300,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h10,1'b1,1'b0,64'h200,  32'd1,1'b0));
    vecs.push_back(mk("res_tgt_mis",   1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b1,64'h304, 1'b1,1'b1,5'h00,1'b1,1'b1,64'h304,  32'd2,1'b0));
    vecs.push_back(mk("enq_80b",       1'b0,1'b1,64'h80,                 1'b1,64'h300,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b1,1'b0,64'h304,  32'd2,1'b0));
    vecs.push_back(mk("res_nt_mis",    1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h00,1'b0,1'b1,64'h84,   32'd3,1'b0));
    // fall-through PC wraps modulo 2^64
    vecs.push_back(mk("enq_top",       1'b0,1'b1,64'hFFFF_FFFF_FFFF_FFFC,1'b1,64'h10,   1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b0,1'b0,64'h84,   32'd3,1'b0));
    vecs.push_back(mk("res_wrap_pc",   1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h1F,1'b0,1'b1,64'h0,    32'd4,1'b0));
    // fill, drop when full, pop+enqueue, wrap
    vecs.push_back(mk("fill_1000",     1'b0,1'b1,64'h1000,               1'b0,64'h1004, 1'b0,1'b0,64'h0,   1'b1,1'b0,5'h1F,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("fill_1004",     1'b0,1'b1,64'h1004,               1'b0,64'h1008, 1'b0,1'b0,64'h0,   1'b1,1'b0,5'h1F,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("fill_1008",     1'b0,1'b1,64'h1008,               1'b0,64'h100C, 1'b0,1'b0,64'h0,   1'b1,1'b0,5'h1F,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("fill_100c",     1'b0,1'b1,64'h100C,               1'b0,64'h1010, 1'b0,1'b0,64'h0,   1'b0,1'b0,5'h1F,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("full_drop",     1'b0,1'b1,64'h2000,               1'b1,64'h3000, 1'b0,1'b0,64'h0,   1'b0,1'b0,5'h1F,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("res_full_enq",  1'b0,1'b1,64'h2000,               1'b1,64'h3000, 1'b1,1'b0,64'h0,   1'b1,1'b1,5'h00,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("res_enq_pair",  1'b0,1'b1,64'h1010,               1'b1,64'h1800, 1'b1,1'b0,64'h0,   1'b1,1'b1,5'h01,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("enq_refill",    1'b0,1'b1,64'h1014,               1'b0,64'h1018, 1'b0,1'b0,64'h0,   1'b0,1'b0,5'h01,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("res_1008",      1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h02,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("res_100c",      1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h03,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("res_1010_tk",   1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b1,64'h1800,1'b1,1'b1,5'h04,1'b1,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("res_1014",      1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h05,1'b0,1'b0,64'h0,    32'd4,1'b0));
    // flush with same-cycle wrong-path enqueue
    vecs.push_back(mk("enq_500",       1'b0,1'b1,64'h500,                1'b0,64'h504,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h05,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("enq_504",       1'b0,1'b1,64'h504,                1'b0,64'h508,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h05,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("enq_508",       1'b0,1'b1,64'h508,                1'b0,64'h50C,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h05,1'b0,1'b0,64'h0,    32'd4,1'b0));
    vecs.push_back(mk("mis_enq_drop",  1'b0,1'b1,64'h600,                1'b0,64'h604,  1'b1,1'b1,64'h900, 1'b1,1'b1,5'h00,1'b1,1'b1,64'h900,  32'd5,1'b0));
    vecs.push_back(mk("one_pulse",     1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b1,1'b0,64'h900,  32'd5,1'b0));
    // refill proves the queue was emptied and the dropped enqueue never landed
    vecs.push_back(mk("post_700",      1'b0,1'b1,64'h700,                1'b0,64'h704,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b1,1'b0,64'h900,  32'd5,1'b0));
    vecs.push_back(mk("post_704",      1'b0,1'b1,64'h704,                1'b0,64'h708,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b1,1'b0,64'h900,  32'd5,1'b0));
    vecs.push_back(mk("post_708",      1'b0,1'b1,64'h708,                1'b0,64'h70C,  1'b0,1'b0,64'h0,   1'b1,1'b0,5'h00,1'b1,1'b0,64'h900,  32'd5,1'b0));
    vecs.push_back(mk("post_70c",      1'b0,1'b1,64'h70C,                1'b0,64'h710,  1'b0,1'b0,64'h0,   1'b0,1'b0,5'h00,1'b1,1'b0,64'h900,  32'd5,1'b0));
    vecs.push_back(mk("res_700",       1'b0,1'b0,64'h0,                  1'b0,64'h0,    1'b1,1'b0,64'h0,   1'b1,1'b1,5'h00,1'b0,1'b0,64'h900,  32'd5,1'b0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Underflow is sticky and produces no update.
    run_vec(mk("uf_rst",        1'b1,1'b0,64'h0,  1'b0,64'h0,  1'b0,1'b0,64'h0,  1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b0));
    run_vec(mk("uf_res_empty",  1'b0,1'b0,64'h0,  1'b0,64'h0,  1'b1,1'b1,64'h77, 1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b1));
    run_vec(mk("uf_idle",       1'b0,1'b0,64'h0,  1'b0,64'h0,  1'b0,1'b0,64'h0,  1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b1));
    run_vec(mk("uf_enq",        1'b0,1'b1,64'h40, 1'b0,64'h44, 1'b0,1'b0,64'h0,  1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b1));
    run_vec(mk("uf_res_ok",     1'b0,1'b0,64'h0,  1'b0,64'h0,  1'b1,1'b0,64'h0,  1'b1,1'b1,5'h10,1'b0,1'b0,64'h0,32'd0,1'b1));

    // Reset mid-stream beats a simultaneous mispredict and enqueue.
    run_vec(mk("rst_enq_a",     1'b0,1'b1,64'h200,1'b0,64'h204,1'b0,1'b0,64'h0,  1'b1,1'b0,5'h10,1'b0,1'b0,64'h0,32'd0,1'b1));
    run_vec(mk("rst_enq_b",     1'b0,1'b1,64'h204,1'b1,64'h400,1'b0,1'b0,64'h0,  1'b1,1'b0,5'h10,1'b0,1'b0,64'h0,32'd0,1'b1));
    run_vec(mk("rst_with_res",  1'b1,1'b1,64'h208,1'b0,64'h20C,1'b1,1'b1,64'h999,1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b0));
    run_vec(mk("post_rst_idle", 1'b0,1'b0,64'h0,  1'b0,64'h0,  1'b0,1'b0,64'h0,  1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b0));
    run_vec(mk("post_rst_res",  1'b0,1'b0,64'h0,  1'b0,64'h0,  1'b1,1'b0,64'h0,  1'b1,1'b0,5'h00,1'b0,1'b0,64'h0,32'd0,1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
